// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider FSM states,
// operand widths, most-negative constants and op-bit field positions.
package mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int XLEN_DEF = 64;
  localparam int WORD_W   = 32;

  localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MOST_NEG_32 = 32'h8000_0000;

  // Latched op bits
  localparam int OP_SIGNED_BIT = 0;
  localparam int OP_REM_BIT    = 1;
  localparam int OP_WORD_BIT   = 2;
  localparam int OP_W          = 3;

endpackage

// File: rtl/div_special_detect.sv
// Combinational divide-by-zero / signed-overflow / early-out detection and
// formation of the immediate result for those cases. Also produces the
// operand magnitudes used by the iterative datapath.
// Optional feature macro: DIV_EARLY_OUT_EN (|dividend| < |divisor| shortcut).
module div_special_detect
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            special,
  output logic [XLEN-1:0] special_result
);

  localparam int HALF = XLEN / 2;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  logic            div_zero;
  logic            ovf;
  logic            early;
  logic [XLEN-1:0] raw;

  // Magnitudes, special-case flags and the special result
  always_comb begin
    mag_a    = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    mag_b    = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    div_zero = (b == '0);
    if (is_word) begin
      ovf = is_signed && (a[HALF-1:0] == HALF'(MOST_NEG_32)) && (b[HALF-1:0] == '1);
    end else begin
      ovf = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end
`ifdef DIV_EARLY_OUT_EN
    early = !div_zero && (mag_a < mag_b);
`else
    early = 1'b0;
`endif
    if (div_zero) begin
      raw = is_rem ? a : '1;
    end else if (ovf) begin
      raw = is_rem ? '0 : a;
    end else begin
      raw = is_rem ? a : '0;
    end
    special        = div_zero || ovf || early;
    special_result = is_word ? sext_word(raw) : raw;
  end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider (one quotient bit per cycle) for RV64
// div/divu/rem/remu and the *w word forms, with valid/ready request and
// response handshakes. Special cases answer one cycle after accept.
// Optional feature macro: DIV_EARLY_OUT_EN (handled in div_special_detect).
module div_iter_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_signed,
  input  logic            req_rem,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_state_e state, state_next;
  logic              accept;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   op_next, op_p0;
  logic              a_sign_p0, b_sign_p0;
  logic [XLEN-1:0]   rem_p0, quo_p0, dvs_p0, result_p0;

  logic signed [XLEN-1:0] opa, opb;
  logic [XLEN-1:0]   mag_a, mag_b, special_result;
  logic              special;

  logic [XLEN:0]     shifted, diff;
  logic              step_ge;
  logic [XLEN-1:0]   q_fix, r_fix, sel_fix, fix_result;

  // Operand conditioning: word ops use the low half, sign- or zero-extended
  always_comb begin
    op_next                = '0;
    op_next[OP_SIGNED_BIT] = req_signed;
    op_next[OP_REM_BIT]    = req_rem;
    op_next[OP_WORD_BIT]   = req_word;
    if (req_word) begin
      opa = req_signed ? sext_word(req_src1) : {{HALF{1'b0}}, req_src1[HALF-1:0]};
      opb = req_signed ? sext_word(req_src2) : {{HALF{1'b0}}, req_src2[HALF-1:0]};
    end else begin
      opa = req_src1;
      opb = req_src2;
    end
  end

  div_special_detect #(.XLEN(XLEN)) u_special (
    .a              (opa),
    .b              (opb),
    .is_signed      (req_signed),
    .is_rem         (req_rem),
    .is_word        (req_word),
    .mag_a          (mag_a),
    .mag_b          (mag_b),
    .special        (special),
    .special_result (special_result)
  );

  // Restoring step and final sign/width fix-up
  always_comb begin
    shifted    = {rem_p0, quo_p0[XLEN-1]};
    diff       = shifted - {1'b0, dvs_p0};
    step_ge    = ~diff[XLEN];
    q_fix      = cond_neg(quo_p0, op_p0[OP_SIGNED_BIT] && (a_sign_p0 ^ b_sign_p0));
    r_fix      = cond_neg(rem_p0, op_p0[OP_SIGNED_BIT] && a_sign_p0);
    sel_fix    = op_p0[OP_REM_BIT] ? r_fix : q_fix;
    fix_result = op_p0[OP_WORD_BIT] ? sext_word(sel_fix) : sel_fix;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          accept     = 1'b1;
          state_next = special ? S_DONE : S_CALC;
        end
      end
      S_CALC:  if (cnt == CNT_W'(1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Iteration counter and response register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      result_p0 <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= special ? '0 : (req_word ? CNT_W'(HALF) : CNT_W'(XLEN));
      end else if (state == S_CALC) begin
        cnt <= cnt - 1'b1;
      end
      if (accept && special) result_p0 <= special_result;
      else if (state == S_FIX) result_p0 <= fix_result;
    end
  end

  // ---- stage p0: operand latch and iterative datapath ----
  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0     <= op_next;
      a_sign_p0 <= opa[XLEN-1];
      b_sign_p0 <= opb[XLEN-1];
      rem_p0    <= '0;
      quo_p0    <= req_word ? (mag_a << HALF) : mag_a;
      dvs_p0    <= mag_b;
    end else if (state == S_CALC) begin
      rem_p0 <= step_ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_p0 <= {quo_p0[XLEN-2:0], step_ge};
    end
  end

  assign resp_result = result_p0;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: vector table plus handshake, flush and
// reset sequences.
module tb_div_iter_unit;

  logic        clock = 1'b0;
  logic        reset, flush, req_valid, req_ready, req_signed, req_rem, req_word;
  logic [63:0] req_src1, req_src2, resp_result;
  logic        resp_valid, resp_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  div_iter_unit #(.XLEN(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_signed  (req_signed),
    .req_rem     (req_rem),
    .req_word    (req_word),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result)
  );

  typedef struct {
    logic        s;
    logic        r;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 66;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%016h required=0x%016h", name, act, exp);
    end
  endtask

  // Wait for IDLE, present one request, release it after the accept edge
  task automatic issue(input logic s, input logic r, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_signed = s; req_rem = r; req_word = w;
    req_src1 = a; req_src2 = b; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // Count cycles from accept until resp_valid (1 = cycle right after accept)
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic seen;

    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_signed = 1'b0; req_rem = 1'b0; req_word = 1'b0;
    req_src1 = '0; req_src2 = '0;

    //            s  r  w  src1                      src2                      expected                  lat
    vecs.push_back('{1, 0, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFA, 66});
    vecs.push_back('{1, 1, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFE, 66});
    vecs.push_back('{0, 1, 0, 64'd100,                 64'd7,                  64'd2,                   66});
    vecs.push_back('{1, 0, 0, 64'h1234,                64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{1, 1, 0, 64'h1234,                64'd0,                  64'h1234,                1});
    vecs.push_back('{1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1});
    vecs.push_back('{1, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{0, 0, 1, 64'hDEAD_0000_FFFF_FFFE, 64'd2,                  64'h0000_0000_7FFF_FFFF, 34});
    vecs.push_back('{1, 0, 0, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 66});
    vecs.push_back('{0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 66});
    vecs.push_back('{1, 0, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFD, 34});
    vecs.push_back('{1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 34});
    vecs.push_back('{0, 1, 1, 64'h0000_0000_8000_0001, 64'd0,                  64'hFFFF_FFFF_8000_0001, 1});
    vecs.push_back('{0, 0, 0, 64'd3,                   64'd10,                 64'd0,                   EARLY_LAT});
    vecs.push_back('{1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10,                 64'hFFFF_FFFF_FFFF_FFFD, EARLY_LAT});

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_req_ready",   {63'd0, req_ready},  64'd1);
    check("rst_resp_valid",  {63'd0, resp_valid}, 64'd0);
    check("rst_resp_result", resp_result,         64'd0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      issue(vecs[i].s, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].b);
      wait_resp(lat);
      check($sformatf("vec%0d_result", i), resp_result, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_valid_drop", i), {63'd0, resp_valid}, 64'd0);
    end

    // Backpressure: hold the response for 5 cycles
    resp_ready = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    wait_resp(lat);
    check("bp_latency", 64'(lat), 64'd66);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      check("bp_valid_held", {63'd0, resp_valid}, 64'd1);
      check("bp_result_held", resp_result, 64'd14);
      check("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp_release_valid", {63'd0, resp_valid}, 64'd0);
    check("bp_release_ready", {63'd0, req_ready}, 64'd1);

    // Flush during CALC: the result never appears
    issue(1'b0, 1'b0, 1'b0, 64'd1000, 64'd7);
    repeat (10) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_req_ready", {63'd0, req_ready}, 64'd1);
    check("flush_resp_valid", {63'd0, resp_valid}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clock);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("flush_no_resp", {63'd0, seen}, 64'd0);

    // Flush in IDLE with a request present: not accepted
    @(negedge clock);
    req_signed = 1'b0; req_rem = 1'b0; req_word = 1'b0;
    req_src1 = 64'd5; req_src2 = 64'd0; req_valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", {63'd0, req_ready}, 64'd1);
    check("flush_idle_valid", {63'd0, resp_valid}, 64'd0);

    // New request after flush
    issue(1'b0, 1'b0, 1'b0, 64'd9, 64'd3);
    wait_resp(lat);
    check("post_flush_result", resp_result, 64'd3);
    check("post_flush_latency", 64'(lat), 64'd66);
    @(posedge clock);
    #1;

    // Reset mid-operation clears everything
    issue(1'b1, 1'b0, 1'b0, 64'd50, 64'd5);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_resp_result", resp_result, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clock);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("midrst_no_resp", {63'd0, seen}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
